// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and client indices for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic CLI_CPU = 1'b0;
    localparam logic CLI_EXT = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt,
    output logic       winner
);

    // On a tie the client that was not served last takes the slot.
    always_comb begin
        winner = CLI_CPU;
        gnt    = 2'b00;
        if (req == 2'b11) begin
            winner = ~last_gnt;
        end else if (req[1]) begin
            winner = CLI_EXT;
        end
        if (req != 2'b00) begin
            gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client req/gnt/ack arbiter and sequencer for the shared word memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 7,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          c0_req,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_gnt,
    output logic          c0_ack,
    output logic [DW-1:0] c0_rdata,
    input  logic          c1_req,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_gnt,
    output logic          c1_ack,
    output logic [DW-1:0] c1_rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = 3;

    state_t        state;
    state_t        state_nx;
    logic          last_gnt;
    logic          owner;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [CW-1:0] cnt;
    logic [1:0]    pick_gnt;
    logic          pick_win;

    rr_arb2 u_rr_arb2 (
        .req      ({c1_req, c0_req}),
        .last_gnt (last_gnt),
        .gnt      (pick_gnt),
        .winner   (pick_win)
    );

    always_comb begin
        state_nx  = state;
        c0_gnt    = 1'b0;
        c1_gnt    = 1'b0;
        c0_ack    = 1'b0;
        c1_ack    = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (pick_gnt != 2'b00) begin
                    c0_gnt   = pick_gnt[0];
                    c1_gnt   = pick_gnt[1];
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_cs    = 1'b1;
                mem_we    = cmd_we;
                mem_addr  = cmd_addr;
                mem_wdata = cmd_wdata;
                state_nx  = cmd_we ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == CW'(1)) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                c0_ack   = (owner == CLI_CPU);
                c1_ack   = (owner == CLI_EXT);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            last_gnt  <= CLI_EXT;
            owner     <= CLI_CPU;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cnt       <= '0;
            c0_rdata  <= '0;
            c1_rdata  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    // Command is captured once; requester inputs are don't-care afterwards.
                    if (pick_gnt != 2'b00) begin
                        owner     <= pick_win;
                        cmd_we    <= pick_win ? c1_we    : c0_we;
                        cmd_addr  <= pick_win ? c1_addr  : c0_addr;
                        cmd_wdata <= pick_win ? c1_wdata : c0_wdata;
                    end
                end
                ST_ISSUE: begin
                    if (!cmd_we) begin
                        cnt <= CW'(RD_LAT);
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        if (owner == CLI_EXT) begin
                            c1_rdata <= mem_rdata;
                        end else begin
                            c0_rdata <= mem_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    last_gnt <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-client arbiter and sequencer for the single 128-word data/instruction memory. It lets the multicycle CPU core (client 0) and a second bus master (client 1: program loader / debug port) share the memory without contention. Each client uses a req/gnt/ack handshake, and the arbiter alone drives the memory's CS, WE, address and write data. It sits between the CPU and the memory; the top level resolves the bidirectional bus from mem_wdata and mem_rdata.

Parameters:
AW, 7, word-address width (memory depth 2^AW)
DW, 32, data width
RD_LAT, 1, memory read latency in cycles from the CS cycle to valid mem_rdata; legal range 1..4

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
c0_req  input  1  client 0 requests one access; held until c0_gnt
c0_we  input  1  client 0: 1 = write, 0 = read
c0_addr  input  AW  client 0 word address
c0_wdata  input  DW  client 0 write data
c0_gnt  output  1  one-cycle pulse: client 0 request accepted, command latched
c0_ack  output  1  one-cycle pulse: client 0 access complete
c0_rdata  output  DW  client 0 read data; valid with c0_ack, held until c0's next read ack
c1_req, c1_we, c1_addr, c1_wdata, c1_gnt, c1_ack, c1_rdata  same as client 0, for client 1
mem_cs  output  1  memory chip select
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data
busy  output  1  high in every state except IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Encoding is set in the package.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one client requests, it wins.
  - If both request, the winner is the client not granted last (round robin, via a last_gnt register).
  - The winner's gnt pulses high this cycle. Its we/addr/wdata are latched into cmd registers at the clock edge. Next state is ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_cs=1, mem_we=latched we, mem_addr and mem_wdata from the latched command.
  - Write: next state is RESP.
  - Read: load the wait counter with RD_LAT; next state is WAIT.
- WAIT:
  - mem_cs=0. The counter decrements each cycle.
  - In the cycle where the counter equals 1, mem_rdata is sampled into the owner's rdata register, and next state is RESP.
  - WAIT therefore lasts exactly RD_LAT cycles.
- RESP (1 cycle): the owner's ack=1; last_gnt is updated to the owner; next state is IDLE.
- Latency, with gnt in cycle t:
  - write: mem_cs/mem_we in t+1, ack in t+2
  - read: mem_cs in t+1, ack in t+2+RD_LAT
  - throughput: one access per 3 cycles (write) or per 3+RD_LAT cycles (read)
- Outputs are zero outside their states. mem_addr and mem_wdata read 0 when mem_cs=0.
- gnt and ack are never high for both clients in the same cycle.
- A req asserted while the arbiter is busy is ignored until IDLE; the requester keeps it held. A req dropped before gnt means no access.
- Inputs are ignored after gnt; changing req/addr/wdata mid-access has no effect.
- Reset values:
  - state=IDLE; all outputs 0; c0_rdata=c1_rdata=0
  - last_gnt=1, so client 0 wins the first tie
  - cmd registers and counter cleared
- Reset mid-operation: the in-flight access is abandoned with no ack. A write already issued in ISSUE is not undone.
- Address wrap is not applicable: the address is passed through unmodified, AW bits.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3
  - client index constants CLI_CPU=1'b0, CLI_EXT=1'b1
- Sub-module rr_arb2: a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_gnt. Outputs: onehot gnt[1:0], winner index.
  - Instantiated once. The FSM, cmd registers, counter and rdata registers stay in mem_arbiter.

Test Plan:
- Reset then c0 read addr 7'h05, mem returns 32'hDEADBEEF (RD_LAT=1), gnt at t: mem_cs=1/mem_we=0/mem_addr=5 at t+1; c0_ack=1 and c0_rdata=DEADBEEF at t+3; busy low at t+4.
- c1 write addr 7'h7F data 32'h12345678, gnt at t: mem_cs=mem_we=1, mem_addr=7F, mem_wdata=12345678 at t+1 only; c1_ack at t+2; c0 signals stay 0 throughout.
- Both clients hold req continuously after reset: grant order c0,c1,c0,c1 over 4 accesses. No cycle has both gnt or both ack high.
- RD_LAT=3 build, c0 read with memory data changing every cycle: c0_rdata equals mem_rdata sampled exactly 3 cycles after the CS cycle; ack at gnt+5.
- RST asserted during WAIT of a c1 read: next cycle state is IDLE, no c1_ack, all outputs 0. Then simultaneous c0/c1 requests grant c0 first.
- c1_req dropped while a c0 access is in progress, and c0 changes addr after gnt: no c1 access occurs, and the c0 access uses the address latched at gnt.
